// File: rtl/autorepeat_control.sv
// Auto-repeat controller for up to eight independent push buttons.
// A press gives one immediate increment step. Holding the button past a delay
// starts repeated steps, first at a slow rate and then at a fast rate. With
// LATCH set, a release during auto-repeat keeps it running until the next press.
// Each step leaves as a one-cycle pulse on target A or target B, chosen by sel.
module autorepeat_control #(
  parameter int CH           = 2,
  parameter int DELAY_TICKS  = 2,
  parameter int REPEAT_TICKS = 1,
  parameter int FAST_TICKS   = 1,
  parameter int FAST_AFTER   = 4,
  parameter int LATCH        = 1
) (
  input  logic          ck,
  input  logic          reset_n,
  input  logic          tick,
  input  logic [CH-1:0] btn,
  input  logic          sel,
  output logic [CH-1:0] up_a,
  output logic [CH-1:0] up_b,
  output logic [CH-1:0] auto_on
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HOLD_WAIT  = 3'd1,
    ST_AUTO_HELD  = 3'd2,
    ST_AUTO_LATCH = 3'd3,
    ST_STOP       = 3'd4
  } state_t;

  // Thresholds are compared against the counter value before it increments,
  // so each one is stored as "period minus one".
  localparam logic [7:0] DELAY_LAST   = 8'(DELAY_TICKS - 1);
  localparam logic [7:0] REPEAT_LAST  = 8'(REPEAT_TICKS - 1);
  localparam logic [7:0] FAST_LAST    = 8'(FAST_TICKS - 1);
  localparam logic [3:0] FAST_AFTER_C = 4'(FAST_AFTER);
  localparam logic       LATCH_EN     = (LATCH != 0);

  // Step counter increment that stops at 15, so a long hold never drops back to the slow rate.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'd15) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  logic [CH-1:0] step_all_s;
  logic [CH-1:0] auto_all_s;
  logic [CH-1:0] up_a_r;
  logic [CH-1:0] up_b_r;
  logic [CH-1:0] auto_on_r;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t     state_r;
    state_t     state_s;
    logic [7:0] tcnt_r;
    logic [7:0] tcnt_s;
    logic [3:0] scnt_r;
    logic [3:0] scnt_s;
    logic       step_s;
    logic [7:0] period_last_s;
    logic       rep_fire_s;

    // Slow period until FAST_AFTER steps have gone out, fast period after that.
    assign period_last_s = (scnt_r < FAST_AFTER_C) ? REPEAT_LAST : FAST_LAST;
    assign rep_fire_s    = (tcnt_r == period_last_s);

    // Next-state and step decision for this channel. A button edge takes priority over a tick.
    always_comb begin
      state_s = state_r;
      tcnt_s  = tcnt_r;
      scnt_s  = scnt_r;
      step_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (btn[i]) begin
            step_s  = 1'b1;
            state_s = ST_HOLD_WAIT;
            tcnt_s  = 8'd0;
            scnt_s  = 4'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HOLD_WAIT: begin
          if (!btn[i]) begin
            state_s = ST_IDLE;
          end else if (tick) begin
            if (tcnt_r == DELAY_LAST) begin
              state_s = ST_AUTO_HELD;
              tcnt_s  = 8'd0;
            end else begin
              tcnt_s = tcnt_r + 8'd1;
            end
          end else begin
            tcnt_s = tcnt_r;
          end
        end
        ST_AUTO_HELD, ST_AUTO_LATCH: begin
          if ((state_r == ST_AUTO_HELD) && !btn[i]) begin
            state_s = LATCH_EN ? ST_AUTO_LATCH : ST_IDLE;
          end else if ((state_r == ST_AUTO_LATCH) && btn[i]) begin
            state_s = ST_STOP;
          end else if (tick) begin
            if (rep_fire_s) begin
              step_s = 1'b1;
              tcnt_s = 8'd0;
              scnt_s = sat_inc(scnt_r);
            end else begin
              tcnt_s = tcnt_r + 8'd1;
            end
          end else begin
            tcnt_s = tcnt_r;
          end
        end
        ST_STOP: begin
          if (!btn[i]) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_STOP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          tcnt_s  = 8'd0;
          scnt_s  = 4'd0;
        end
      endcase
    end

    // Per-channel state and counter registers.
    always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
        state_r <= ST_IDLE;
        tcnt_r  <= 8'd0;
        scnt_r  <= 4'd0;
      end else begin
        state_r <= state_s;
        tcnt_r  <= tcnt_s;
        scnt_r  <= scnt_s;
      end
    end

    assign step_all_s[i] = step_s;
    assign auto_all_s[i] = (state_s == ST_AUTO_HELD) || (state_s == ST_AUTO_LATCH);
  end

  // Output registers. sel in the deciding cycle picks the target, so only one target fires per step.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      up_a_r    <= {CH{1'b0}};
      up_b_r    <= {CH{1'b0}};
      auto_on_r <= {CH{1'b0}};
    end else begin
      up_a_r    <= step_all_s & {CH{sel}};
      up_b_r    <= step_all_s & {CH{~sel}};
      auto_on_r <= auto_all_s;
    end
  end

  assign up_a    = up_a_r;
  assign up_b    = up_b_r;
  assign auto_on = auto_on_r;

endmodule

// File: tb/tb_autorepeat_control.sv
// Bench for autorepeat_control. It runs two instances side by side:
//   dut0: default parameters (latching, REPEAT = FAST = 1).
//   dut1: CH=3, DELAY=3, REPEAT=3, FAST=1, FAST_AFTER=2, non-latching.
// A phase-based model tracks every channel and checks all outputs on every cycle.
module tb_autorepeat_control;

  logic       ck;
  logic       reset_n;
  logic       tick;
  logic       sel;
  logic [1:0] btn0;
  logic [2:0] btn1;
  logic [1:0] ua0, ub0, ao0;
  logic [2:0] ua1, ub1, ao1;

  int total = 0;
  int bad   = 0;
  int tph   = 0;
  logic rnd = 1'b0;

  autorepeat_control dut0 (
    .ck(ck), .reset_n(reset_n), .tick(tick), .btn(btn0), .sel(sel),
    .up_a(ua0), .up_b(ub0), .auto_on(ao0)
  );

  autorepeat_control #(
    .CH(3), .DELAY_TICKS(3), .REPEAT_TICKS(3), .FAST_TICKS(1), .FAST_AFTER(2), .LATCH(0)
  ) dut1 (
    .ck(ck), .reset_n(reset_n), .tick(tick), .btn(btn1), .sel(sel),
    .up_a(ua1), .up_b(ub1), .auto_on(ao1)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Model channel phases.
  localparam int M_IDLE = 0, M_WAIT = 1, M_HELD = 2, M_LATCHED = 3, M_STOPPED = 4;
  typedef struct packed { int ph; int tc; int sc; } ch_t;
  ch_t m0 [2];
  ch_t m1 [3];
  logic [1:0] ea0, eb0, eo0;
  logic [2:0] ea1, eb1, eo1;

  // Advance one channel by one clock. Counters count ticks up to the full period.
  function automatic void adv(inout ch_t c, input logic b, input logic t, input int dly,
                              input int rep, input int fst, input int fa, input int lat,
                              output logic step);
    step = 1'b0;
    case (c.ph)
      M_IDLE: if (b) begin step = 1'b1; c.ph = M_WAIT; c.tc = 0; c.sc = 0; end
      M_WAIT: begin
        if (!b) c.ph = M_IDLE;
        else if (t) begin
          c.tc = c.tc + 1;
          if (c.tc == dly) begin c.ph = M_HELD; c.tc = 0; end
        end
      end
      M_HELD, M_LATCHED: begin
        if (c.ph == M_HELD && !b) c.ph = (lat != 0) ? M_LATCHED : M_IDLE;
        else if (c.ph == M_LATCHED && b) c.ph = M_STOPPED;
        else if (t) begin
          c.tc = c.tc + 1;
          if (c.tc == ((c.sc < fa) ? rep : fst)) begin
            step = 1'b1;
            c.tc = 0;
            if (c.sc < 15) c.sc = c.sc + 1;
          end
        end
      end
      M_STOPPED: if (!b) c.ph = M_IDLE;
      default: c.ph = M_IDLE;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout", nm);
  endtask

  // Model update at each edge, then compare every output shortly after the edge.
  always @(posedge ck) begin : cmp
    logic st;
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) m0[c] = '0;
      for (int c = 0; c < 3; c++) m1[c] = '0;
      ea0 = '0; eb0 = '0; eo0 = '0; ea1 = '0; eb1 = '0; eo1 = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        adv(m0[c], btn0[c], tick, 2, 1, 1, 4, 1, st);
        ea0[c] = st & sel;
        eb0[c] = st & ~sel;
        eo0[c] = (m0[c].ph == M_HELD) || (m0[c].ph == M_LATCHED);
      end
      for (int c = 0; c < 3; c++) begin
        adv(m1[c], btn1[c], tick, 3, 3, 1, 2, 0, st);
        ea1[c] = st & sel;
        eb1[c] = st & ~sel;
        eo1[c] = (m1[c].ph == M_HELD) || (m1[c].ph == M_LATCHED);
      end
    end
    #1;
    chk("m_up_a0", 8'(ua0), 8'(ea0));
    chk("m_up_b0", 8'(ub0), 8'(eb0));
    chk("m_auto0", 8'(ao0), 8'(eo0));
    chk("m_up_a1", 8'(ua1), 8'(ea1));
    chk("m_up_b1", 8'(ub1), 8'(eb1));
    chk("m_auto1", 8'(ao1), 8'(eo1));
    chk("never_both0", 8'(ua0 & ub0), 8'd0);
    chk("never_both1", 8'(ua1 & ub1), 8'd0);
  end

  // One clock: drive inputs on the falling edge, return just after the next rising edge.
  task automatic next(input logic [1:0] b0, input logic [2:0] b1, input logic s);
    @(negedge ck);
    if (rnd) tick = ($urandom_range(0, 2) == 0);
    else begin
      tick = (tph == 3);
      tph  = (tph + 1) % 4;
    end
    btn0 = b0;
    btn1 = b1;
    sel  = s;
    @(posedge ck);
    #1;
  endtask

  task automatic align_no_tick(input logic [1:0] b0, input logic [2:0] b1, input logic s);
    while (tph == 3) next(b0, b1, s);
  endtask

  task automatic do_reset();
    @(negedge ck);
    reset_n = 1'b0;
    @(negedge ck);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int n, g, cb0, cb1;
    logic s;
    logic [1:0] nb0;
    logic [2:0] nb1;
    reset_n = 1'b0; tick = 1'b0; btn0 = 2'b00; btn1 = 3'b000; sel = 1'b0;
    repeat (2) @(negedge ck);
    chk("rst_up_a", 8'(ua0), 8'd0);
    chk("rst_up_b", 8'(ub0), 8'd0);
    chk("rst_auto", 8'(ao0 | ao1), 8'd0);
    @(negedge ck);
    reset_n = 1'b1;

    // Short press with sel=1: one up_a pulse, no repeat.
    next(2'b01, 3'b000, 1'b1);
    chk("press_up_a", 8'(ua0), 8'h01);
    chk("press_up_b", 8'(ub0), 8'h00);
    next(2'b01, 3'b000, 1'b1);
    chk("press_once", 8'(ua0), 8'h00);
    cb0 = 0;
    repeat (8) begin next(2'b00, 3'b000, 1'b1); cb0 += int'(ua0[0]); end
    chk("press_no_more", 8'(cb0), 8'd0);
    chk("press_idle_auto", 8'(ao0), 8'd0);

    // Long hold with sel=0 for 30 ticks on both instances.
    align_no_tick(2'b00, 3'b000, 1'b0);
    n = 0; g = 0; cb0 = 0; cb1 = 0;
    while (n < 30 && g < 400) begin
      next(2'b01, 3'b001, 1'b0);
      g++;
      if (g == 1) chk("hold_first_b", 8'(ub0), 8'h01);
      cb0 += int'(ub0[0]);
      cb1 += int'(ub1[0]);
      if (tick) begin
        n++;
        if (n == 1) chk("auto_off_t1", 8'(ao0), 8'h00);
        if (n == 2) begin
          chk("auto_on_t2", 8'(ao0), 8'h01);
          chk("dut1_wait_t2", 8'(ao1), 8'h00);
        end
        if (n == 3) chk("dut1_on_t3", 8'(ao1), 8'h01);
      end
    end
    if (g >= 400) timeout("hold");
    // dut0: 1 manual step plus one step per tick from tick 3 to tick 30.
    chk("hold_pulses0", 8'(cb0), 8'd29);
    // dut1: 1 manual step, slow steps at ticks 6 and 9, then fast steps at ticks 10..30 with no wrap.
    chk("hold_pulses1", 8'(cb1), 8'd24);

    // Release: dut0 latches and keeps stepping; dut1 stops.
    next(2'b00, 3'b000, 1'b0);
    chk("latch_auto0", 8'(ao0), 8'h01);
    chk("nolatch_auto1", 8'(ao1), 8'h00);
    n = 0; g = 0; cb0 = 0; cb1 = 0;
    while (n < 3 && g < 100) begin
      next(2'b00, 3'b000, 1'b0);
      g++;
      if (tick) n++;
      cb0 += int'(ub0[0]);
      cb1 += int'(ub1[0]);
    end
    if (g >= 100) timeout("latch");
    chk("latch_pulses0", 8'(cb0), 8'd3);
    chk("nolatch_pulses1", 8'(cb1), 8'd0);

    // Press on the same cycle as a repeat tick while latched: no step, go to stop.
    while (tph != 3) next(2'b00, 3'b000, 1'b0);
    next(2'b01, 3'b000, 1'b0);
    chk("stop_no_pulse", 8'(ub0), 8'h00);
    chk("stop_auto_off", 8'(ao0), 8'h00);
    cb0 = 0;
    repeat (8) begin next(2'b00, 3'b000, 1'b0); cb0 += int'(ub0[0]); end
    chk("stop_then_idle", 8'(cb0), 8'd0);

    // Release on the tick that would finish the delay: no step, back to idle.
    align_no_tick(2'b00, 3'b000, 1'b0);
    next(2'b01, 3'b000, 1'b0);
    n = 0; g = 0;
    while (n < 1 && g < 20) begin next(2'b01, 3'b000, 1'b0); g++; if (tick) n++; end
    while (tph != 3) next(2'b01, 3'b000, 1'b0);
    next(2'b00, 3'b000, 1'b0);
    chk("delay_rel_pulse", 8'(ub0), 8'h00);
    chk("delay_rel_auto", 8'(ao0), 8'h00);
    cb0 = 0;
    repeat (8) begin next(2'b00, 3'b000, 1'b0); cb0 += int'(ub0[0]); end
    chk("delay_rel_idle", 8'(cb0 + int'(ao0[0])), 8'd0);

    // Both channels held while sel toggles every cycle.
    s = 1'b1;
    repeat (60) begin next(2'b11, 3'b011, s); s = ~s; end
    repeat (4) next(2'b00, 3'b000, 1'b0);
    next(2'b11, 3'b000, 1'b0);
    repeat (4) next(2'b00, 3'b000, 1'b0);

    // Reset in the middle of latched auto-repeat, with the button already held at release.
    align_no_tick(2'b00, 3'b000, 1'b1);
    n = 0; g = 0;
    while (n < 3 && g < 100) begin next(2'b01, 3'b000, 1'b1); g++; if (tick) n++; end
    next(2'b00, 3'b000, 1'b1);
    next(2'b00, 3'b000, 1'b1);
    chk("pre_rst_auto", 8'(ao0), 8'h01);
    #2;
    reset_n = 1'b0;
    btn0 = 2'b01;
    #1;
    chk("async_rst_up", 8'(ua0 | ub0), 8'd0);
    chk("async_rst_auto", 8'(ao0), 8'd0);
    @(posedge ck);
    #1;
    @(negedge ck);
    tick = 1'b0;
    reset_n = 1'b1;
    @(posedge ck);
    #1;
    chk("rst_rel_pulse", 8'(ua0), 8'h01);
    next(2'b01, 3'b000, 1'b1);
    chk("rst_rel_once", 8'(ua0), 8'h00);
    chk("rst_rel_wait", 8'(ao0), 8'h00);
    repeat (4) next(2'b00, 3'b000, 1'b1);

    // Random stimulus with random ticks and the occasional reset.
    rnd = 1'b1;
    nb0 = 2'b00;
    nb1 = 3'b000;
    repeat (1500) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 7) == 0) nb0[i] = ~nb0[i];
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) nb1[i] = ~nb1[i];
      if ($urandom_range(0, 249) == 0) do_reset();
      else next(nb0, nb1, 1'($urandom_range(0, 1)));
    end
    @(negedge ck);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autorepeat_control.md
AUTOREPEAT_CONTROL -- requirements
Module: autorepeat_control

Interface
REQ-001 The block SHALL have parameter CH, default 2: number of independent button channels (1..8).
REQ-002 The block SHALL have parameter DELAY_TICKS, default 2: tick pulses a button must be held before auto-repeat starts (1..255).
REQ-003 The block SHALL have parameter REPEAT_TICKS, default 1: tick pulses between slow auto-repeat steps (1..255).
REQ-004 The block SHALL have parameter FAST_TICKS, default 1: tick pulses between fast auto-repeat steps (1..REPEAT_TICKS).
REQ-005 The block SHALL have parameter FAST_AFTER, default 4: count of slow auto steps before switching to fast rate (0 = always fast, 1..15).
REQ-006 The block SHALL have parameter LATCH, default 1: 1 = auto-repeat continues after release until the next press; 0 = auto-repeat only while held.
REQ-007 The block SHALL have port ck, input, 1 bit: single clock, rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port tick, input, 1 bit: one-cycle timebase enable pulse shared by all channels.
REQ-010 The block SHALL have port btn, input, CH bits: synchronised, debounced button levels, 1 = pressed.
REQ-011 The block SHALL have port sel, input, 1 bit: destination select, 1 = target A, 0 = target B.
REQ-012 The block SHALL have port up_a, output, CH bits: one-cycle increment pulses to target A.
REQ-013 The block SHALL have port up_b, output, CH bits: one-cycle increment pulses to target B.
REQ-014 The block SHALL have port auto_on, output, CH bits: 1 while the channel is in AUTO_HELD or AUTO_LATCH.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, HOLD_WAIT, AUTO_HELD, AUTO_LATCH and STOP, plus an 8-bit tick counter and a 4-bit saturating step counter.
REQ-016 All outputs SHALL be registered; a step decided in cycle n SHALL appear on up_a/up_b in cycle n+1, for exactly one cycle.
REQ-017 Steps SHALL be routed by sel sampled in the deciding cycle: up_a[i] = step & sel, up_b[i] = step & ~sel; never both.
REQ-018 IDLE, btn[i]=1: one step (manual press); go to HOLD_WAIT; clear tick and step counters.
REQ-019 HOLD_WAIT, btn[i]=0: go to IDLE with no step.
REQ-020 HOLD_WAIT, held, tick with count = DELAY_TICKS-1: go to AUTO_HELD with no step; clear tick counter.
REQ-021 HOLD_WAIT, held, tick with count below DELAY_TICKS-1: increment the tick counter.
REQ-022 AUTO_HELD and AUTO_LATCH SHALL use period P = REPEAT_TICKS while step count < FAST_AFTER, else FAST_TICKS.
REQ-023 AUTO_HELD and AUTO_LATCH, tick with count = P-1: one step; clear tick counter; increment step counter, saturating at 15.
REQ-024 AUTO_HELD, btn[i]=0: go to AUTO_LATCH if LATCH=1, else IDLE; keep tick and step counters.
REQ-025 AUTO_LATCH, btn[i]=1: go to STOP with no step.
REQ-026 STOP: no steps; go to IDLE when btn[i]=0.
REQ-027 Simultaneous tick and btn change SHALL resolve as: the button transition wins and no step is issued in that cycle (HOLD_WAIT release, AUTO_HELD release, AUTO_LATCH press).
REQ-028 A tick with a count below threshold SHALL increment the counter; absent tick, counters SHALL hold.
REQ-029 sel changes SHALL affect only routing, never FSM state or counters.
REQ-030 Channels SHALL never interact; simultaneous steps on several channels SHALL all be issued in the same cycle.

Reset
REQ-031 reset_n=0 SHALL immediately force every channel to IDLE, clear all counters, and drive up_a, up_b and auto_on to 0, including mid-operation.
REQ-032 After reset_n deasserts with btn[i] already 1, the channel SHALL treat the level as a fresh press in the first clock edge (step issued, HOLD_WAIT).

Verification (defaults, tick every 4 cycles)
REQ-033 The bench SHALL cover: press btn[0] with sel=1 for 2 cycles, then release -> exactly one up_a[0] pulse, one cycle after press; state IDLE.
REQ-034 The bench SHALL cover: hold btn[0] with sel=0 -> up_b[0] at press+1; auto_on[0]=1 after 2nd tick; then 4 pulses one tick apart (REPEAT=1), then FAST (1 tick apart); step count saturates at 15 without wrap.
REQ-035 The bench SHALL cover: LATCH=1, release during AUTO_HELD -> pulses continue; press again -> no pulse, auto_on=0; release -> IDLE; LATCH=0 build: release -> IDLE, no further pulses.
REQ-036 The bench SHALL cover: release coinciding with the tick that would complete the delay -> no pulse, IDLE; press coinciding with repeat tick in AUTO_LATCH -> no pulse, STOP.
REQ-037 The bench SHALL cover: CH=2, both channels held, sel toggled every cycle -> per-channel pulses routed per sel at decision cycle, never both up_a[i] and up_b[i] high.
REQ-038 The bench SHALL cover: reset_n pulsed low mid-AUTO_LATCH -> outputs 0 asynchronously; with btn high at release, one pulse on the first edge, then HOLD_WAIT.
